// File: rtl/rc_transfer_buffer.sv
// rtl/rc_transfer_buffer.sv - ring-crossing transfer FIFO between two connect routers
// Registered-only flit_out/bfull so the injecting router can form accept combinationally.
`ifndef CONTROL_N
`define CONTROL_N 32
`endif
`ifndef VALID_F
`define VALID_F 31
`endif

module rc_transfer_buffer #(
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [`CONTROL_N-1:0] flit_in,
  output logic                  bfull,
  output logic [`CONTROL_N-1:0] flit_out,
  input  logic                  accept,
  output logic [PTR_W:0]        bsize,
  output logic                  overflow,
  output logic [STALL_W-1:0]    stall_cnt
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [`CONTROL_N-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W:0]        cnt;
  logic                  is_full;
  logic                  is_empty;
  logic                  push_valid;
  logic                  wr;
  logic                  rd;

  assign is_full    = (cnt == FULL_CNT);
  assign is_empty   = (cnt == '0);
  assign push_valid = push & flit_in[`VALID_F];
  assign wr         = push_valid & ~is_full & ~rst;
  assign rd         = accept & ~is_empty & ~rst;

  assign bfull    = is_full;
  assign bsize    = cnt;
  assign flit_out = is_empty ? '0 : mem[rd_ptr];

  // Storage is not reset; cnt==0 hides stale entries from flit_out.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= flit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_valid & is_full) begin
      overflow <= 1'b1;
    end
  end

  // Head-of-line wait statistic; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (~is_empty & ~accept & (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rc_transfer_buffer.sv
// tb/tb_rc_transfer_buffer.sv - self-checking bench for rc_transfer_buffer
`ifndef CONTROL_N
`define CONTROL_N 32
`endif
`ifndef VALID_F
`define VALID_F 31
`endif

module tb_rc_transfer_buffer;

  localparam int DEPTH     = 4;
  localparam int STALL_MAX = 65535;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  push;
  logic [`CONTROL_N-1:0] flit_in;
  logic                  bfull;
  logic [`CONTROL_N-1:0] flit_out;
  logic                  accept;
  logic [2:0]            bsize;
  logic                  overflow;
  logic [15:0]           stall_cnt;

  rc_transfer_buffer #(.DEPTH(DEPTH), .PTR_W(2), .STALL_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .flit_in   (flit_in),
    .bfull     (bfull),
    .flit_out  (flit_out),
    .accept    (accept),
    .bsize     (bsize),
    .overflow  (overflow),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [`CONTROL_N-1:0] q[$];
  bit                    m_ovf;
  int                    m_stall;

  function automatic logic [31:0] mk(input logic v, input logic [7:0] dest);
    logic [31:0] f;
    f = {v, 7'h00, 16'(($urandom & 32'h0000_ffff) | 32'h1), dest};
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit p, input logic [31:0] f, input bit a);
    bit pv, full, empty;
    if (r) begin
      q.delete();
      m_ovf   = 1'b0;
      m_stall = 0;
      return;
    end
    pv    = p & f[`VALID_F];
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (!empty && !a && m_stall < STALL_MAX) m_stall++;
    if (pv && full) m_ovf = 1'b1;
    if (a && !empty) void'(q.pop_front());
    if (pv && !full) q.push_back(f);
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_out;
    exp_out = (q.size() != 0) ? q[0] : 32'h0;
    check({tag, ".flit_out"},  flit_out,           exp_out);
    check({tag, ".bsize"},     32'(bsize),         32'(q.size()));
    check({tag, ".bfull"},     32'(bfull),         32'(q.size() == DEPTH));
    check({tag, ".overflow"},  32'(overflow),      32'(m_ovf));
    check({tag, ".stall_cnt"}, 32'(stall_cnt),     32'(m_stall));
  endtask

  task automatic cycle(input bit r, input bit p, input logic [31:0] f, input bit a,
                       input bit do_check, input string tag);
    rst = r; push = p; flit_in = f; accept = a;
    model_step(r, p, f, a);
    @(posedge clk);
    #1;
    if (do_check) check_model(tag);
  endtask

  typedef struct {
    bit          push;
    logic [31:0] flit;
    bit          accept;
    int          exp_bsize;
    bit          exp_bfull;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] fa, fb, fc, fd, fe, ff, fg;

  initial begin
    rst = 1'b1; push = 1'b0; flit_in = '0; accept = 1'b0;
    m_ovf = 1'b0; m_stall = 0;

    // Test 1: reset then idle
    cycle(1, 0, 0, 0, 0, "rst");
    cycle(1, 0, 0, 0, 1, "rst");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, "idle");
    check("idle.flit_out_zero", flit_out, 32'h0);
    check("idle.bsize_zero", 32'(bsize), 32'h0);

    // Tests 2-3: fill then drain, table driven with fixed expectations
    fa = mk(1, 8'd5); fb = mk(1, 8'd6); fc = mk(1, 8'd7); fd = mk(1, 8'd8);
    vecs[0] = '{1, fa, 0, 1, 0, fa};
    vecs[1] = '{1, fb, 0, 2, 0, fa};
    vecs[2] = '{1, fc, 0, 3, 0, fa};
    vecs[3] = '{1, fd, 0, 4, 1, fa};
    vecs[4] = '{0, 0,  1, 3, 0, fb};
    vecs[5] = '{0, 0,  1, 2, 0, fc};
    vecs[6] = '{0, 0,  1, 1, 0, fd};
    vecs[7] = '{0, 0,  1, 0, 0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      cycle(0, vecs[i].push, vecs[i].flit, vecs[i].accept, 1, "vec");
      check($sformatf("vec%0d.bsize", i), 32'(bsize), 32'(vecs[i].exp_bsize));
      check($sformatf("vec%0d.bfull", i), 32'(bfull), 32'(vecs[i].exp_bfull));
      check($sformatf("vec%0d.flit_out", i), flit_out, vecs[i].exp_out);
    end
    check("drain.accept_empty", 32'(bsize), 32'h0);
    cycle(0, 0, 0, 1, 1, "accept_empty");

    // Test 4: cnt=2, simultaneous push and pop across pointer wrap
    cycle(0, 1, mk(1, 8'd20), 0, 1, "pp_fill");
    cycle(0, 1, mk(1, 8'd21), 0, 1, "pp_fill");
    for (int i = 0; i < 10; i++) begin
      fe = mk(1, 8'(30 + i));
      cycle(0, 1, fe, 1, 1, "pushpop");
      check("pushpop.bsize_const", 32'(bsize), 32'd2);
    end
    cycle(0, 0, 0, 1, 1, "pp_drain");
    cycle(0, 0, 0, 1, 1, "pp_drain");
    check("pp_drain.empty", flit_out, 32'h0);

    // Test 5: overflow and invalid-flit push
    for (int i = 0; i < 4; i++) cycle(0, 1, mk(1, 8'(40 + i)), 0, 1, "ovf_fill");
    ff = mk(1, 8'd99);
    cycle(0, 1, ff, 0, 1, "ovf_push");
    check("ovf.sticky_set", 32'(overflow), 32'd1);
    cycle(0, 0, 0, 1, 1, "ovf_pop");
    cycle(0, 1, mk(0, 8'd50), 0, 1, "invalid_push");
    check("invalid_push.bsize", 32'(bsize), 32'd3);
    check("ovf.sticky_hold", 32'(overflow), 32'd1);

    // Test 6: stall saturation, then reset mid-transfer
    cycle(1, 0, 0, 0, 1, "rst2");
    cycle(0, 1, mk(1, 8'd60), 0, 1, "stall_push");
    for (int i = 0; i < 65540; i++) cycle(0, 0, 0, 0, 0, "stall");
    check_model("stall");
    check("stall.saturated", 32'(stall_cnt), 32'h0000_ffff);
    cycle(0, 1, mk(1, 8'd61), 0, 1, "pre_rst");
    cycle(0, 1, mk(1, 8'd62), 0, 1, "pre_rst");
    check("pre_rst.bsize3", 32'(bsize), 32'd3);
    cycle(1, 1, mk(1, 8'd63), 1, 1, "mid_rst");
    check("mid_rst.flit_out", flit_out, 32'h0);
    check("mid_rst.bsize", 32'(bsize), 32'h0);
    check("mid_rst.stall", 32'(stall_cnt), 32'h0);
    fg = mk(1, 8'd70);
    cycle(0, 1, fg, 0, 1, "post_rst");
    check("post_rst.first", flit_out, fg);

    // Randomized traffic against the queue model
    for (int i = 0; i < 2000; i++) begin
      bit r, p, a, v;
      r = ($urandom_range(0, 99) == 0);
      p = $urandom_range(0, 2) != 0;
      v = $urandom_range(0, 5) != 0;
      a = $urandom_range(0, 1);
      cycle(r, p, mk(v, 8'($urandom)), a, 1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
